// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control-to-datapath/memory bundle for the multicycle RV32I controller.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       trap;
    logic [2:0] state_o;
    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_write, wb_sel, trap, state_o
    );
    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_write, wb_sel, trap, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM with wait-stated memory handshake and timeout trap.
// Define MCTRL_PERF_EN to add cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    multicycle_ctrl_if.master bus
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, TRAP = 3'd7
    } state_t;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IALU = 7'b0010011, OP_STORE = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_R = 7'b0110011;
    localparam int TW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t state, next;
    logic [TW-1:0] timer;
    logic is_load, is_store, is_ialu, is_br, is_jal, is_jalr, is_r, legal, waiting, timeout;

    assign is_load  = bus.opcode == OP_LOAD;
    assign is_store = bus.opcode == OP_STORE;
    assign is_ialu  = bus.opcode == OP_IALU;
    assign is_br    = bus.opcode == OP_BR;
    assign is_jal   = bus.opcode == OP_JAL;
    assign is_jalr  = bus.opcode == OP_JALR;
    assign is_r     = bus.opcode == OP_R;
    assign legal    = is_load | is_store | is_ialu | is_br | is_jal | is_jalr | is_r;
    assign waiting  = (state == FETCH || state == MEM) && !bus.mem_ready;
    // The last allowed wait cycle is the one where timer reads MEM_TIMEOUT-1.
    assign timeout  = (MEM_TIMEOUT != 0) && waiting && timer == TLIM;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) timer <= '0;
        else if (next != state) timer <= '0;
        else if (waiting) timer <= timer + TW'(1);

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = FETCH;
            FETCH:   next = bus.mem_ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE:  next = legal ? EXEC : TRAP;
            EXEC:    next = (is_load | is_store) ? MEM : is_br ? FETCH : WB;
            MEM:     next = bus.mem_ready ? (is_store ? FETCH : WB) : timeout ? TRAP : MEM;
            WB:      next = FETCH;
            default: next = TRAP;
        endcase
    end

    always_comb begin
        bus.mem_req   = state == FETCH || state == MEM;
        bus.mem_we    = state == MEM && is_store;
        bus.ir_write  = state == FETCH && bus.mem_ready;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'd0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 2'd0;
        bus.reg_write = state == WB;
        bus.wb_sel    = 2'd0;
        bus.trap      = state == TRAP;
        bus.state_o   = state;
        if (state == FETCH) bus.pc_write = bus.mem_ready;
        if (state == EXEC) begin
            bus.alu_src_b = is_load | is_store | is_ialu | is_jalr;
            bus.alu_op    = (is_ialu | is_r) ? 2'd2 : is_br ? 2'd1 : 2'd0;
            bus.pc_write  = is_jal | is_jalr | (is_br & bus.branch_taken);
            bus.pc_src    = is_jalr ? 2'd2 : (is_jal | (is_br & bus.branch_taken)) ? 2'd1 : 2'd0;
        end
        if (state == WB) bus.wb_sel = is_load ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
    end

`ifdef MCTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (next == FETCH && (state == EXEC || state == MEM || state == WB))
                instret_cnt <= instret_cnt + 32'd1;
        end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus queues per-cycle expected outputs, a monitor compares them.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic [2:0] st;
        logic       req, we, irw, pcw;
        logic [1:0] pcs;
        logic       sa, sb;
        logic [1:0] op;
        logic       rw;
        logic [1:0] wb;
        logic       tr;
    } exp_t;

    localparam logic [6:0] LD = 7'b0000011, IA = 7'b0010011, ST = 7'b0100011, BR = 7'b1100011,
                           JL = 7'b1101111, JR = 7'b1100111, RT = 7'b0110011, LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int total = 0, passed = 0, cyc = 0;

    multicycle_ctrl_if bus();
`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                           .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));
`else
    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [2:0] st, input logic req, we, irw, pcw,
                                input logic [1:0] pcs, input logic sa, sb, input logic [1:0] op,
                                input logic rw, input logic [1:0] wb, input logic tr);
        return '{st, req, we, irw, pcw, pcs, sa, sb, op, rw, wb, tr};
    endfunction

    task automatic cy(input logic [6:0] op, input logic bt, input logic rdy, input exp_t e);
        bus.opcode = op;
        bus.branch_taken = bt;
        bus.mem_ready = rdy;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        cyc++;
        if (q.size() != 0) begin
            e = q.pop_front();
            g = '{bus.state_o, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.wb_sel, bus.trap};
            total++;
            if (g === e) passed++;
            else $display("FAIL cycle%0d outputs: got %h (state %0d) expected %h (state %0d)",
                          cyc, g, g.st, e, e.st);
        end
    end

    initial begin
        exp_t z, f_ok, f_wait, dec, trp;
        z      = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        f_ok   = ex(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        f_wait = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec    = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        trp    = ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        bus.opcode = '0; bus.branch_taken = 0; bus.mem_ready = 0;
        @(posedge clk); #1;
        cy(IA, 0, 1, z);
        rst_n = 1'b1;
        cy(IA, 0, 1, z);
        // addi: FETCH, DECODE, EXEC, WB
        cy(IA, 0, 1, f_ok);
        cy(IA, 0, 1, dec);
        cy(IA, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        cy(IA, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // load with three MEM wait cycles
        cy(LD, 0, 1, f_ok);
        cy(LD, 0, 0, dec);
        cy(LD, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cy(LD, 0, 0, ex(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cy(LD, 0, 1, ex(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cy(LD, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        // store, fetch ready only on 4th request cycle (limit boundary, no trap)
        for (int i = 0; i < 3; i++) cy(ST, 0, 0, f_wait);
        cy(ST, 0, 1, f_ok);
        cy(ST, 0, 1, dec);
        cy(ST, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cy(ST, 0, 1, ex(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // beq taken then not taken
        cy(BR, 0, 1, f_ok);
        cy(BR, 0, 0, dec);
        cy(BR, 1, 0, ex(3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        cy(BR, 0, 1, f_ok);
        cy(BR, 0, 0, dec);
        cy(BR, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // JAL, JALR, R-type
        cy(JL, 0, 1, f_ok);
        cy(JL, 0, 0, dec);
        cy(JL, 0, 0, ex(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cy(JL, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        cy(JR, 0, 1, f_ok);
        cy(JR, 0, 0, dec);
        cy(JR, 0, 0, ex(3, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0));
        cy(JR, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        cy(RT, 0, 1, f_ok);
        cy(RT, 0, 0, dec);
        cy(RT, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        cy(RT, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // store interrupted by asynchronous reset in MEM
        cy(ST, 0, 1, f_ok);
        cy(ST, 0, 0, dec);
        cy(ST, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cy(ST, 0, 0, ex(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        cy(ST, 0, 1, z);
        cy(ST, 0, 1, z);
        rst_n = 1'b1;
        cy(ST, 0, 1, z);
        // LUI is illegal: trap holds for 20 cycles regardless of inputs
        cy(LUI, 0, 1, f_ok);
        cy(LUI, 0, 0, dec);
        for (int i = 0; i < 20; i++) cy(LUI, 1'b1, i[0], trp);
        rst_n = 1'b0;
        cy(IA, 0, 0, z);
        rst_n = 1'b1;
        cy(IA, 0, 0, z);
        // fetch timeout: four unanswered request cycles then TRAP
        for (int i = 0; i < 4; i++) cy(IA, 0, 0, f_wait);
        cy(IA, 0, 0, trp);
        cy(IA, 0, 1, trp);
        @(negedge clk); #1;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
